// File: rtl/qspi_fetch_pkg.sv
// Shared definitions for the QSPI line fetcher.
// Contents:
//   phase_t       transfer phase enumeration
//   OPCODE_3B/4B  quad I/O fast-read opcodes for 24/32-bit addressing
//   MODE_CONT/NORM mode bytes with continuous read enabled/disabled
//   phase_len     number of sck periods spent in a phase
//   period_count  total sck periods of one transfer
package qspi_fetch_pkg;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_CMD,
      PH_ADDR,
      PH_MODE,
      PH_DUMMY,
      PH_DATA,
      PH_FINISH
   } phase_t;

   localparam logic [7:0] OPCODE_3B = 8'hEB;
   localparam logic [7:0] OPCODE_4B = 8'hEC;
   localparam logic [7:0] MODE_CONT = 8'hA5;
   localparam logic [7:0] MODE_NORM = 8'hFF;

   function automatic logic [7:0] phase_len(phase_t ph, int addr_width, int line_bytes,
                                            int dummy_cycles);
      case (ph)
         PH_CMD:   return 8'd8;
         PH_ADDR:  return 8'(addr_width / 4);
         PH_MODE:  return 8'd2;
         PH_DUMMY: return 8'(dummy_cycles);
         PH_DATA:  return 8'(2 * line_bytes);
         default:  return 8'd1;
      endcase
   endfunction

   function automatic int period_count(int addr_width, int line_bytes, int dummy_cycles,
                                       logic skip_cmd);
      return (skip_cmd ? 0 : 8) + addr_width / 4 + 2 + dummy_cycles + 2 * line_bytes;
   endfunction

endpackage

// File: rtl/qspi_line_shifter.sv
// Nibble shift-in register that assembles a fetched line from the quad data bus.
// Each byte arrives high nibble first; completed bytes enter at the top and move
// down, so the first byte received ends up at line[7:0].
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, clears line
//   clear     resynchronises the nibble pairing at the start of a transfer
//   shift_en  sample din this cycle
//   din       quad data in
//   line      assembled line
module qspi_line_shifter #(
   parameter int LINE_BYTES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    shift_en,
   input  logic [3:0]              din,
   output logic [LINE_BYTES*8-1:0] line
);

   localparam int W = LINE_BYTES * 8;

   logic [3:0] hi_nib;
   logic       low_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         line     <= '0;
         hi_nib   <= 4'h0;
         low_next <= 1'b0;
      end else if (clear) begin
         low_next <= 1'b0;
      end else if (shift_en) begin
         if (!low_next) begin
            hi_nib   <= din;
            low_next <= 1'b1;
         end else begin
            line     <= {hi_nib, din, line[W-1:8]};
            low_next <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/qspi_line_fetcher.sv
// QSPI quad-I/O line fetcher: issues a fast-read (cmd, address, mode, dummy)
// and collects LINE_BYTES of data into line.
// Each phase item is one sck period of two clk cycles, sck low first.
// Optional build macro: QSPI_FETCH_CONT_READ_EN enables continuous-read mode
// (mode byte 0xA5, command phase skipped once a transfer has completed).
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   rd, addr       one-cycle fetch request with line address (taken in IDLE)
//   abort          ends any transfer in progress
//   busy, done     transfer in progress / one-cycle line-valid pulse
//   line           fetched data, byte 0 (lowest address) in line[7:0]
//   sck, ce_n      flash clock and active-low chip enable
//   din, dout, douten  quad I/O; douten high drives dout
//
// state     | meaning
// ----------+-----------------------------------------------
// PH_IDLE   | ce_n high, waiting for rd
// PH_CMD    | 8 periods, opcode serial on dout[0]
// PH_ADDR   | ADDR_WIDTH/4 periods, address MSB nibble first
// PH_MODE   | 2 periods, mode byte high nibble first
// PH_DUMMY  | DUMMY_CYCLES periods, bus released
// PH_DATA   | 2*LINE_BYTES periods, din sampled at sck fall
// PH_FINISH | one clk with ce_n high before done
module qspi_line_fetcher
   import qspi_fetch_pkg::*;
#(
   parameter int LINE_BYTES   = 16,
   parameter int ADDR_WIDTH   = 24,
   parameter int DUMMY_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rd,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic [LINE_BYTES*8-1:0] line,
   output logic                    sck,
   output logic                    ce_n,
   input  logic [3:0]              din,
   output logic [3:0]              dout,
   output logic                    douten
);

   localparam logic [7:0] OPCODE = (ADDR_WIDTH == 32) ? OPCODE_4B : OPCODE_3B;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

   phase_t                  state, state_nxt, first_ph, follow_ph;
   logic [7:0]              cnt, cnt_nxt;
   logic                    half, half_nxt;
   logic                    done_q, done_nxt;
   logic                    start, shift_en;
   logic                    cont_flag;
   logic                    active;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [4:0]              nib_sel;

   function automatic phase_t next_phase(phase_t ph);
      case (ph)
         PH_CMD:   return PH_ADDR;
         PH_ADDR:  return PH_MODE;
         PH_MODE:  return (DUMMY_CYCLES == 0) ? PH_DATA : PH_DUMMY;
         PH_DUMMY: return PH_DATA;
         PH_DATA:  return PH_FINISH;
         default:  return PH_IDLE;
      endcase
   endfunction

`ifdef QSPI_FETCH_CONT_READ_EN
   localparam logic [7:0] MODE_BYTE = MODE_CONT;

   // Flash stays in continuous-read after a completed transfer with mode 0xA5;
   // an abort leaves its state uncertain, so fall back to a full command.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         cont_flag <= 1'b0;
      end else if (state == PH_FINISH) begin
         cont_flag <= 1'b1;
      end
   end
`else
   localparam logic [7:0] MODE_BYTE = MODE_NORM;

   assign cont_flag = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= PH_IDLE;
         cnt    <= 8'd0;
         half   <= 1'b0;
         done_q <= 1'b0;
         addr_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         half   <= half_nxt;
         done_q <= done_nxt;
         if (start) begin
            addr_q <= addr & ADDR_MASK;
         end
      end
   end

   // cnt is a down-counter of periods left in the current phase; a period
   // ends on the edge that closes its sck-high half.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      half_nxt  = half;
      done_nxt  = 1'b0;
      start     = 1'b0;
      shift_en  = 1'b0;
      first_ph  = cont_flag ? PH_ADDR : PH_CMD;
      follow_ph = next_phase(state);
      case (state)
         PH_IDLE: begin
            if (rd) begin
               start     = 1'b1;
               state_nxt = first_ph;
               cnt_nxt   = phase_len(first_ph, ADDR_WIDTH, LINE_BYTES, DUMMY_CYCLES) - 8'd1;
               half_nxt  = 1'b0;
            end
         end
         PH_FINISH: begin
            state_nxt = PH_IDLE;
            done_nxt  = 1'b1;
         end
         default: begin
            half_nxt = ~half;
            if (half) begin
               shift_en = (state == PH_DATA);
               if (cnt == 8'd0) begin
                  state_nxt = follow_ph;
                  cnt_nxt   = phase_len(follow_ph, ADDR_WIDTH, LINE_BYTES, DUMMY_CYCLES) - 8'd1;
               end else begin
                  cnt_nxt = cnt - 8'd1;
               end
            end
         end
      endcase
      if (abort) begin
         state_nxt = PH_IDLE;
         half_nxt  = 1'b0;
         done_nxt  = 1'b0;
         start     = 1'b0;
         shift_en  = 1'b0;
      end
   end

   // Outputs are decoded from registered state; dout depends only on state
   // and cnt, which move on the edge that starts a period (sck going low).
   assign active  = state inside {PH_CMD, PH_ADDR, PH_MODE, PH_DUMMY, PH_DATA};
   assign ce_n    = ~active;
   assign sck     = active & half;
   assign douten  = state inside {PH_CMD, PH_ADDR, PH_MODE};
   assign busy    = (state != PH_IDLE);
   assign done    = done_q;
   assign nib_sel = {cnt[2:0], 2'b00};

   always_comb begin
      dout = 4'h0;
      case (state)
         PH_CMD:  dout = {3'b000, OPCODE[cnt[2:0]]};
         PH_ADDR: dout = addr_q[nib_sel +: 4];
         PH_MODE: dout = MODE_BYTE[{cnt[0], 2'b00} +: 4];
         default: dout = 4'h0;
      endcase
   end

   qspi_line_shifter #(
      .LINE_BYTES (LINE_BYTES)
   ) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clear    (start),
      .shift_en (shift_en),
      .din      (din),
      .line     (line)
   );

endmodule
